// File: rtl/rle_sched_pkg.sv
// Shared types and constants for the zero-run-length encoder stream scheduler.
package rle_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARB    = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } sched_state_e;

  // Encoder output format: a zero run is emitted as RLE_ZERO_MARK then the run count.
  localparam logic [7:0] RLE_ZERO_MARK = 8'h00;
  localparam logic [7:0] RLE_MAX_RUN   = 8'hFF;

  localparam int DEF_LEN_W = 20;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner, wrapping.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [IDX_W-1:0] ptr
);

  int   idx;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IDX_W'(idx);
      end
    end
  end

  // Pointer holds the last owner; resetting it to N-1 makes channel 0 win first.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= IDX_W'(N - 1);
    end else if (advance && found) begin
      ptr <= gnt_idx;
    end
  end

endmodule

// File: rtl/rle_stream_scheduler.sv
// Job-granular round-robin scheduler feeding one shared zero-RLE encoder engine.
// Optional stall watchdog enabled by defining RLE_SCHED_WDOG_EN.
module rle_stream_scheduler
  import rle_sched_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int LEN_W    = DEF_LEN_W,
  parameter int WDOG_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH*LEN_W-1:0] req_len,
  output logic [NUM_CH-1:0]       grant,
  input  logic [NUM_CH-1:0]       ch_valid,
  input  logic [NUM_CH*8-1:0]     ch_data,
  output logic [NUM_CH-1:0]       ch_ready,
  output logic                    enc_valid,
  output logic [7:0]              enc_data,
  output logic                    enc_last,
  input  logic                    enc_ready,
  input  logic                    enc_obyte,
  input  logic                    enc_idle,
  output logic                    done,
  output logic [2:0]              done_ch,
  output logic [LEN_W-1:0]        done_ilen,
  output logic [LEN_W:0]          done_olen,
  output logic                    err
);

  localparam int IDX_W = $clog2(NUM_CH);

  function automatic logic [LEN_W:0] sat_inc(input logic [LEN_W:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  sched_state_e      state;
  logic [NUM_CH-1:0] grant_r;
  logic              err_r;
  logic              drain_first;
  logic [IDX_W-1:0]  owner;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  in_cnt;
  logic [LEN_W:0]    out_cnt;
  logic [NUM_CH-1:0] arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic [IDX_W-1:0]  arb_ptr;
  logic              arb_adv;
  logic [LEN_W-1:0]  sel_len;
  logic              streaming;
  logic              xfer;
  logic              abort;

  assign arb_adv = (state == ST_ARB) && (|req);
  assign sel_len = req_len[arb_idx*LEN_W +: LEN_W];

  rr_arbiter #(
    .N     (NUM_CH),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (arb_adv),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .ptr     (arb_ptr)
  );

  // Pass-through path: the owner's stream is wired straight to the encoder.
  assign streaming = (state == ST_STREAM);
  assign enc_valid = streaming && ch_valid[owner];
  assign enc_data  = streaming ? ch_data[owner*8 +: 8] : 8'h00;
  assign ch_ready  = (streaming && enc_ready) ? grant_r : '0;
  assign xfer      = enc_valid && enc_ready;
  assign enc_last  = enc_valid && (in_cnt == len - 1'b1);

`ifdef RLE_SCHED_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYC + 1);
  logic [WD_W-1:0] stall;

  always_ff @(posedge clk) begin
    if (rst || !streaming || xfer) begin
      stall <= '0;
    end else begin
      stall <= stall + 1'b1;
    end
  end

  // Fires on the WDOG_CYC-th consecutive cycle without a transfer.
  assign abort = streaming && !xfer && (stall == WD_W'(WDOG_CYC - 1));
`else
  // Watchdog disabled: the job waits indefinitely for its bytes.
  assign abort = (WDOG_CYC < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant_r     <= '0;
      err_r       <= 1'b0;
      drain_first <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) state <= ST_ARB;
        end
        ST_ARB: begin
          if (|req) begin
            grant_r <= arb_gnt;
            err_r   <= 1'b0;
            state   <= (sel_len == '0) ? ST_DONE : ST_STREAM;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_STREAM: begin
          if (xfer && enc_last) begin
            state       <= ST_DRAIN;
            drain_first <= 1'b1;
          end else if (abort) begin
            state <= ST_DONE;
            err_r <= 1'b1;
          end
        end
        ST_DRAIN: begin
          // enc_idle may still reflect the pre-flush encoder in the entry cycle.
          drain_first <= 1'b0;
          if (!drain_first && enc_idle) state <= ST_DONE;
        end
        ST_DONE: begin
          grant_r <= '0;
          err_r   <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      ST_ARB: begin
        owner   <= arb_idx;
        len     <= sel_len;
        in_cnt  <= '0;
        out_cnt <= '0;
      end
      ST_STREAM: begin
        if (xfer) in_cnt <= in_cnt + 1'b1;
        if (enc_obyte) out_cnt <= sat_inc(out_cnt);
      end
      ST_DRAIN: begin
        if (enc_obyte) out_cnt <= sat_inc(out_cnt);
      end
      default: ;
    endcase
  end

  assign grant     = grant_r;
  assign done      = (state == ST_DONE);
  assign done_ch   = done ? 3'(owner) : 3'd0;
  assign done_ilen = done ? in_cnt : '0;
  assign done_olen = done ? out_cnt : '0;
  assign err       = done && err_r;

endmodule

// File: tb/tb_rle_stream_scheduler.sv
// Directed bench for rle_stream_scheduler with a behavioural zero-RLE encoder model.
module tb_rle_stream_scheduler;

  localparam int NUM_CH = 4;
  localparam int LEN_W  = 20;
`ifdef RLE_SCHED_WDOG_EN
  localparam int TB_WDOG = 16;
`else
  localparam int TB_WDOG = 1024;
`endif

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_CH-1:0]       req = '0;
  logic [NUM_CH*LEN_W-1:0] req_len = '0;
  logic [NUM_CH-1:0]       grant;
  logic [NUM_CH-1:0]       ch_valid = '0;
  logic [NUM_CH*8-1:0]     ch_data = '0;
  logic [NUM_CH-1:0]       ch_ready;
  logic                    enc_valid;
  logic [7:0]              enc_data;
  logic                    enc_last;
  logic                    enc_ready = 1'b1;
  logic                    enc_obyte = 1'b0;
  logic                    enc_idle = 1'b1;
  logic                    done;
  logic [2:0]              done_ch;
  logic [LEN_W-1:0]        done_ilen;
  logic [LEN_W:0]          done_olen;
  logic                    err;

  rle_stream_scheduler #(
    .NUM_CH   (NUM_CH),
    .LEN_W    (LEN_W),
    .WDOG_CYC (TB_WDOG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_len   (req_len),
    .grant     (grant),
    .ch_valid  (ch_valid),
    .ch_data   (ch_data),
    .ch_ready  (ch_ready),
    .enc_valid (enc_valid),
    .enc_data  (enc_data),
    .enc_last  (enc_last),
    .enc_ready (enc_ready),
    .enc_obyte (enc_obyte),
    .enc_idle  (enc_idle),
    .done      (done),
    .done_ch   (done_ch),
    .done_ilen (done_ilen),
    .done_olen (done_olen),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sources, encoder model and monitors
  logic [7:0] src_mem [NUM_CH][32];
  int         src_len [NUM_CH];
  int         src_pos [NUM_CH];
  bit         gap_en = 1'b0;
  bit         rdy_toggle = 1'b0;
  logic [7:0] pend[$];
  logic [7:0] outq[$];
  logic [7:0] inq[$];
  int         run = 0;
  int         cyc = 0;
  int         last_xfer_cyc = 0;
  int         last_cnt = 0;
  int         last_pos = 0;
  int         viol = 0;
  int         ev_cnt = 0;

  initial begin
    for (int c = 0; c < NUM_CH; c++) begin
      src_len[c] = 0;
      src_pos[c] = 0;
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      pend.delete();
      run = 0;
      enc_obyte <= 1'b0;
      enc_idle  <= 1'b1;
      enc_ready <= 1'b1;
    end else begin
      if (enc_obyte && pend.size() > 0) outq.push_back(pend.pop_front());
      if (enc_valid && enc_ready) begin
        last_xfer_cyc = cyc;
        inq.push_back(enc_data);
        if (enc_last) begin
          last_cnt++;
          last_pos = inq.size();
        end
        if (enc_data == 8'h00) begin
          if (run == 255) begin
            pend.push_back(8'h00);
            pend.push_back(8'hFF);
            run = 0;
          end
          run++;
        end else begin
          if (run > 0) begin
            pend.push_back(8'h00);
            pend.push_back(8'(run));
            run = 0;
          end
          pend.push_back(enc_data);
        end
        if (enc_last && run > 0) begin
          pend.push_back(8'h00);
          pend.push_back(8'(run));
          run = 0;
        end
      end
      for (int c = 0; c < NUM_CH; c++)
        if (ch_valid[c] && ch_ready[c]) src_pos[c]++;
      enc_obyte <= (pend.size() > 0);
      enc_idle  <= (pend.size() == 0) && (run == 0);
      enc_ready <= rdy_toggle ? !enc_ready : 1'b1;
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (src_pos[c] < src_len[c] && (!gap_en || $urandom_range(0, 3) != 0)) begin
        ch_valid[c]         = 1'b1;
        ch_data[c*8 +: 8]   = src_mem[c][src_pos[c]];
      end else begin
        ch_valid[c]         = 1'b0;
      end
    end
    if ((grant & (grant - 1'b1)) != '0) viol++;
    if ((ch_ready & ~grant) != '0) viol++;
    if (enc_valid && grant == '0) viol++;
    if (enc_valid) ev_cnt++;
  end

  logic [2:0]       d_ch;
  logic [LEN_W-1:0] d_ilen;
  logic [LEN_W:0]   d_olen;
  logic             d_err;
  int               d_cyc;
  bit               ok;
  int               t0;
  int               order [5];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    for (int c = 0; c < NUM_CH; c++) src_len[c] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    inq.delete();
    outq.delete();
    last_cnt = 0;
    viol = 0;
  endtask

  task automatic wait_done(input int bound, input bit refill, output bit got);
    got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) begin
        d_ch   = done_ch;
        d_ilen = done_ilen;
        d_olen = done_olen;
        d_err  = err;
        d_cyc  = cyc;
        if (refill) src_pos[done_ch] = 0;
        got = 1'b1;
      end
      if (got) break;
    end
  endtask

  task automatic start_job(input int c, input int len, input int avail);
    src_pos[c] = 0;
    src_len[c] = avail;
    req_len[c*LEN_W +: LEN_W] = LEN_W'(len);
    req[c] = 1'b1;
  endtask

  initial begin
    do_reset();
    check_eq("rst_grant", grant, 0);
    check_eq("rst_enc_valid", enc_valid, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ch_ready", ch_ready, 0);
    check_eq("rst_err", err, 0);

    // Single job on channel 1
    src_mem[1][0] = 8'h11; src_mem[1][1] = 8'h00; src_mem[1][2] = 8'h00;
    src_mem[1][3] = 8'h00; src_mem[1][4] = 8'h22;
    start_job(1, 5, 5);
    t0 = cyc;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (grant != '0) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("single_grant_seen", ok, 1);
    check_eq("single_grant_lat", cyc - t0, 2);
    check_eq("single_grant", grant, 4'b0010);
    wait_done(100, 1'b0, ok);
    req = '0;
    check_eq("single_done_seen", ok, 1);
    check_eq("single_done_ch", d_ch, 1);
    check_eq("single_ilen", d_ilen, 5);
    check_eq("single_olen", d_olen, 4);
    check_eq("single_err", d_err, 0);
    check_eq("single_last_cnt", last_cnt, 1);
    check_eq("single_last_pos", last_pos, 5);
    check_eq("single_out_size", outq.size(), 4);
    if (outq.size() == 4) begin
      check_eq("single_out0", outq[0], 8'h11);
      check_eq("single_out1", outq[1], 8'h00);
      check_eq("single_out2", outq[2], 8'h03);
      check_eq("single_out3", outq[3], 8'h22);
    end

    // Contention: all channels, requests held
    do_reset();
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 0; k < 3; k++) src_mem[c][k] = 8'(8'h10 * (c + 1) + k + 1);
    for (int c = 0; c < NUM_CH; c++) start_job(c, 3, 3);
    for (int j = 0; j < 5; j++) begin
      wait_done(200, 1'b1, ok);
      check_eq($sformatf("cont_done_seen%0d", j), ok, 1);
      order[j] = ok ? int'(d_ch) : -1;
    end
    req = '0;
    check_eq("cont_order0", order[0], 0);
    check_eq("cont_order1", order[1], 1);
    check_eq("cont_order2", order[2], 2);
    check_eq("cont_order3", order[3], 3);
    check_eq("cont_order4", order[4], 0);
    check_eq("cont_grant_rules", viol, 0);

    // Backpressure and source gaps on a 16-byte job
    do_reset();
    src_mem[0][0]  = 8'h01; src_mem[0][1]  = 8'h02; src_mem[0][2]  = 8'h00; src_mem[0][3]  = 8'h00;
    src_mem[0][4]  = 8'h03; src_mem[0][5]  = 8'h00; src_mem[0][6]  = 8'h04; src_mem[0][7]  = 8'h05;
    src_mem[0][8]  = 8'h00; src_mem[0][9]  = 8'h00; src_mem[0][10] = 8'h00; src_mem[0][11] = 8'h06;
    src_mem[0][12] = 8'h07; src_mem[0][13] = 8'h00; src_mem[0][14] = 8'h08; src_mem[0][15] = 8'h09;
    gap_en = 1'b1;
    rdy_toggle = 1'b1;
    start_job(0, 16, 16);
    wait_done(400, 1'b0, ok);
    req = '0;
    gap_en = 1'b0;
    rdy_toggle = 1'b0;
    check_eq("bp_done_seen", ok, 1);
    check_eq("bp_ilen", d_ilen, 16);
    check_eq("bp_olen", d_olen, 17);
    check_eq("bp_in_count", inq.size(), 16);
    for (int i = 0; i < 16; i++)
      if (i < inq.size()) check_eq($sformatf("bp_byte%0d", i), inq[i], src_mem[0][i]);
    check_eq("bp_grant_rules", viol, 0);

    // Zero-length job on channel 2
    do_reset();
    ev_cnt = 0;
    start_job(2, 0, 0);
    t0 = cyc;
    wait_done(20, 1'b0, ok);
    req = '0;
    check_eq("zl_done_seen", ok, 1);
    check_eq("zl_done_lat", d_cyc - t0, 2);
    check_eq("zl_done_ch", d_ch, 2);
    check_eq("zl_ilen", d_ilen, 0);
    check_eq("zl_olen", d_olen, 0);
    repeat (3) @(negedge clk);
    check_eq("zl_no_enc_valid", ev_cnt, 0);

    // Reset in the middle of a stream, then a clean re-run
    do_reset();
    for (int k = 0; k < 8; k++) src_mem[0][k] = 8'(k + 1);
    start_job(0, 8, 3);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (inq.size() >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("mid_three_bytes", ok, 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_grant", grant, 0);
    check_eq("mid_rst_enc_valid", enc_valid, 0);
    check_eq("mid_rst_done", done, 0);
    rst = 1'b0;
    inq.delete();
    outq.delete();
    src_pos[0] = 0;
    src_len[0] = 8;
    wait_done(200, 1'b0, ok);
    req = '0;
    check_eq("rerun_done_seen", ok, 1);
    check_eq("rerun_done_ch", d_ch, 0);
    check_eq("rerun_ilen", d_ilen, 8);
    check_eq("rerun_olen", d_olen, 8);
    check_eq("rerun_in_count", inq.size(), 8);

`ifdef RLE_SCHED_WDOG_EN
    // Stalled source trips the watchdog
    do_reset();
    for (int k = 0; k < 10; k++) src_mem[1][k] = 8'(8'h40 + k);
    start_job(1, 10, 2);
    wait_done(200, 1'b0, ok);
    req = '0;
    check_eq("wd_done_seen", ok, 1);
    check_eq("wd_err", d_err, 1);
    check_eq("wd_ilen", d_ilen, 2);
    check_eq("wd_done_ch", d_ch, 1);
    check_eq("wd_latency", d_cyc - last_xfer_cyc, 16);
    check_eq("wd_no_last", last_cnt, 0);
    do_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1);
  end

endmodule
